lane_serdes_converter: RTL and testbench

Multi-lane, parameterised serial/parallel converter between the wide parallel word bank and narrow per-lane serial links in the training datapath. A single word register per lane is serialised (shift-out) or deserialised (shift-in) SLICE bits per beat under a start/finish handshake, or bulk-loaded from the parallel bus. Serial transfers carry valid/ready flow control, which lets stalled links pause a transfer without losing data.

---
 rtl/lane_serdes_converter.sv | 128 ++++++++++++
 tb/tb_lane_serdes_converter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_serdes_converter.sv
// Multi-lane serial/parallel converter: one word register per lane, shifted SLICE bits per beat or bulk-loaded.
// Define LSC_MSB_FIRST_EN to transfer the most-significant slice of each word first (default LSB-first).
module lane_serdes_converter #(
  parameter int LANES    = 16,
  parameter int SLICE    = 2,
  parameter int WORD_LEN = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   mode,
  input  logic                         start,
  output logic                         busy,
  output logic                         finish,
  input  logic [LANES*SLICE-1:0]       ser_in,
  input  logic                         ser_in_valid,
  output logic [LANES*SLICE-1:0]       ser_out,
  output logic                         ser_out_valid,
  input  logic                         ser_out_ready,
  input  logic [LANES*WORD_LEN-1:0]    par_in,
  output logic [LANES*WORD_LEN-1:0]    par_out
);

  localparam int BEATS = WORD_LEN / SLICE;
  localparam int BW    = (BEATS > 2) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT_IN, SHIFT_OUT} state_t;

  state_t                              state_q, state_d;
  logic [BW-1:0]                       beat_q, beat_d;
  logic                                finish_q, finish_d;
  logic [LANES-1:0][WORD_LEN-1:0]      words_q, words_d, shift_w;
  logic [LANES-1:0][BEATS-1:0][SLICE-1:0] slot_sel;
  logic                                load_en, cap_en, out_en;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    finish_d = 1'b0;
    load_en  = 1'b0;
    cap_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          beat_d = '0;
          case (mode)
            2'd0:    state_d = SHIFT_OUT;
            2'd1:    state_d = SHIFT_IN;
            2'd2:    state_d = LOAD;
            default: state_d = IDLE;
          endcase
        end
      end
      LOAD: begin
        load_en  = 1'b1;
        finish_d = 1'b1;
        state_d  = IDLE;
      end
      SHIFT_IN: begin
        if (ser_in_valid) begin
          cap_en = 1'b1;
          if (beat_q == LAST_BEAT) begin
            beat_d   = '0;
            finish_d = 1'b1;
            state_d  = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      SHIFT_OUT: begin
        if (ser_out_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d   = '0;
            finish_d = 1'b1;
            state_d  = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    words_d = load_en ? par_in : shift_w;
  end

  assign out_en        = (state_q == SHIFT_OUT);
  assign ser_out_valid = out_en;
  assign busy          = (state_q != IDLE);
  assign finish        = finish_q;
  assign par_out       = words_q;

  // Each slot is a fixed slice of the word; the beat counter only selects among them.
  genvar gi, gb;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      for (gb = 0; gb < BEATS; gb++) begin : g_slot
`ifdef LSC_MSB_FIRST_EN
        localparam int LO = WORD_LEN - SLICE - gb * SLICE;
`else
        localparam int LO = gb * SLICE;
`endif
        assign slot_sel[gi][gb] = words_q[gi][LO +: SLICE];
        assign shift_w[gi][LO +: SLICE] = (cap_en && beat_q == BW'(gb)) ?
                                          ser_in[gi*SLICE +: SLICE] : slot_sel[gi][gb];
      end
      assign ser_out[gi*SLICE +: SLICE] = out_en ? slot_sel[gi][beat_q] : '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      finish_q <= 1'b0;
      words_q  <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      finish_q <= finish_d;
      words_q  <= words_d;
    end
  end

endmodule

// File: tb/tb_lane_serdes_converter.sv
// Self-checking bench for lane_serdes_converter (LANES=4, SLICE=2, WORD_LEN=8), table vectors plus random traffic.
module tb_lane_serdes_converter;
  localparam int LANES = 4;
  localparam int SLICE = 2;
  localparam int WL    = 8;
  localparam int BEATS = WL / SLICE;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [1:0]             mode;
  logic                   start;
  logic                   busy, finish;
  logic [LANES*SLICE-1:0] ser_in;
  logic                   ser_in_valid;
  logic [LANES*SLICE-1:0] ser_out;
  logic                   ser_out_valid;
  logic                   ser_out_ready;
  logic [LANES*WL-1:0]    par_in, par_out;

  lane_serdes_converter #(.LANES(LANES), .SLICE(SLICE), .WORD_LEN(WL)) dut (
    .clk(clk), .reset(reset), .mode(mode), .start(start), .busy(busy), .finish(finish),
    .ser_in(ser_in), .ser_in_valid(ser_in_valid), .ser_out(ser_out), .ser_out_valid(ser_out_valid),
    .ser_out_ready(ser_out_ready), .par_in(par_in), .par_out(par_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pin;
    logic [7:0]  exp_beat [BEATS];
  } vec_t;
  vec_t vecs [2];

  int mw [LANES];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int slot_lo(input int b);
`ifdef LSC_MSB_FIRST_EN
    return WL - SLICE * (b + 1);
`else
    return b * SLICE;
`endif
  endfunction

  function automatic logic [7:0] exp_ser(input int b);
    int r = 0;
    for (int k = 0; k < LANES; k++)
      r += ((mw[k] >> slot_lo(b)) % 4) * (4 ** k);
    return 8'(r);
  endfunction

  function automatic logic [31:0] exp_par();
    longint r = 0;
    for (int k = 0; k < LANES; k++) r += longint'(mw[k]) * (256 ** k);
    return 32'(r);
  endfunction

  task automatic model_load(input logic [31:0] pin);
    for (int k = 0; k < LANES; k++) mw[k] = int'((pin >> (8 * k)) & 32'hFF);
  endtask

  task automatic model_cap(input int b, input logic [7:0] data);
    int lo = slot_lo(b);
    for (int k = 0; k < LANES; k++) begin
      int s = int'((data >> (SLICE * k)) & 8'h3);
      mw[k] = (mw[k] & ~(3 << lo)) | (s << lo);
    end
  endtask

  task automatic do_load(input logic [31:0] pin);
    par_in = pin; mode = 2'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check("load_busy", busy, 1'b1);
    tick();
    model_load(pin);
    check("load_finish", finish, 1'b1);
    check("load_busy_low", busy, 1'b0);
    check("load_par_out", par_out, exp_par());
  endtask

  // Serialise the current words with random stalls; expectations follow handshake count.
  task automatic serialise(input int stall_pct);
    int hs = 0;
    int cyc = 0;
    mode = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("ser_busy", busy, 1'b1);
    while (hs < BEATS && cyc < 200) begin
      check("ser_valid", ser_out_valid, 1'b1);
      check($sformatf("ser_out_beat%0d", hs), ser_out, exp_ser(hs));
      check("ser_no_early_finish", finish, 1'b0);
      ser_out_ready = ($urandom_range(99) >= stall_pct);
      ser_in_valid = $urandom_range(1);
      ser_in = 8'($urandom());
      tick();
      if (ser_out_ready) hs++;
      cyc++;
    end
    ser_in_valid = 1'b0;
    check("ser_timeout", (cyc >= 200), 1'b0);
    check("ser_finish", finish, 1'b1);
    check("ser_busy_low", busy, 1'b0);
    check("ser_valid_idle", ser_out_valid, 1'b0);
    check("ser_out_idle", ser_out, 8'h00);
    check("ser_nondestructive", par_out, exp_par());
  endtask

  task automatic deserialise(input logic [7:0] data [BEATS], input int gaps [BEATS]);
    int busy_cnt;
    mode = 2'd1; start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    for (int b = 0; b < BEATS; b++) begin
      for (int g = 0; g < gaps[b]; g++) begin
        ser_in_valid = 1'b0; ser_in = 8'($urandom());
        tick();
        check("des_gap_no_finish", finish, 1'b0);
        if (busy) busy_cnt++;
      end
      ser_in_valid = 1'b1; ser_in = data[b];
      tick();
      model_cap(b, data[b]);
      if (busy) busy_cnt++;
      if (b < BEATS - 1) check("des_mid_finish", finish, 1'b0);
    end
    ser_in_valid = 1'b0;
    check("des_finish", finish, 1'b1);
    check("des_par_out", par_out, exp_par());
    begin
      int tot = BEATS;
      for (int b = 0; b < BEATS; b++) tot += gaps[b];
      check("des_busy_cycles", busy_cnt, tot);
    end
  endtask

  initial begin
    logic [7:0] d [BEATS];
    int gp [BEATS];
    reset = 1'b0; mode = 2'd0; start = 1'b0; ser_in = '0; ser_in_valid = 1'b0;
    ser_out_ready = 1'b0; par_in = '0;
    for (int k = 0; k < LANES; k++) mw[k] = 0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_finish", finish, 1'b0);
    check("rst_valid", ser_out_valid, 1'b0);
    check("rst_ser_out", ser_out, 8'h00);
    check("rst_par_out", par_out, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    vecs[0].pin = 32'hDEADBEEF;
    vecs[0].exp_beat = '{8'h9B, 8'hFF, 8'h6E, 8'hEB};
    vecs[1].pin = 32'h12345678;
    vecs[1].exp_beat = '{8'h88, 8'h16, 8'h77, 8'h05};
`ifdef LSC_MSB_FIRST_EN
    for (int v = 0; v < 2; v++) begin
      model_load(vecs[v].pin);
      for (int b = 0; b < BEATS; b++) vecs[v].exp_beat[b] = exp_ser(b);
    end
`endif

    // Table vectors: load, then serialise with ready held high.
    for (int v = 0; v < 2; v++) begin
      do_load(vecs[v].pin);
      ser_out_ready = 1'b1; mode = 2'd0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int b = 0; b < BEATS; b++) begin
        check($sformatf("tbl%0d_beat%0d", v, b), ser_out, vecs[v].exp_beat[b]);
        check("tbl_no_finish", finish, 1'b0);
        tick();
      end
      check($sformatf("tbl%0d_finish", v), finish, 1'b1);
      check("tbl_busy_low", busy, 1'b0);
    end

    // Back-to-back: serialise called in the finish cycle re-sends the same words.
    serialise(0);
    serialise(0);
    // Back-pressure with heavy stalls.
    serialise(60);

    // Deserialise with gaps between beats 2 and 3.
    d = '{8'h1B, 8'hE4, 8'h00, 8'hFF};
    gp = '{0, 0, 2, 0};
    deserialise(d, gp);
    serialise(30);

    // Random traffic.
    for (int it = 0; it < 6; it++) begin
      for (int b = 0; b < BEATS; b++) begin d[b] = 8'($urandom()); gp[b] = $urandom_range(2); end
      deserialise(d, gp);
      serialise($urandom_range(50));
      if (it % 2 == 1) begin
        do_load(32'($urandom()));
        serialise($urandom_range(50));
      end
    end

    // start while busy and ser_in_valid outside SHIFT_IN are ignored.
    ser_out_ready = 1'b0; mode = 2'd0; start = 1'b1;
    tick();
    mode = 2'd2; par_in = ~par_out; ser_in_valid = 1'b1; ser_in = 8'hA5;
    tick();
    check("ign_busy", busy, 1'b1);
    check("ign_ser_out_held", ser_out, exp_ser(0));
    check("ign_par_out", par_out, exp_par());
    start = 1'b0; ser_in_valid = 1'b0; ser_out_ready = 1'b1;
    for (int b = 0; b < BEATS; b++) begin
      check($sformatf("ign_beat%0d", b), ser_out, exp_ser(b));
      tick();
    end
    check("ign_finish", finish, 1'b1);
    check("ign_par_out_after", par_out, exp_par());

    // mode 3 start: stays idle, no finish.
    mode = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("m3_busy", busy, 1'b0);
    check("m3_finish", finish, 1'b0);
    tick();
    check("m3_finish_late", finish, 1'b0);

    // Reset mid shift-in: two beats captured, then asynchronous reset.
    mode = 2'd1; start = 1'b1;
    tick();
    start = 1'b0; ser_in_valid = 1'b1;
    ser_in = 8'h5A; tick();
    ser_in = 8'hC3; tick();
    ser_in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    for (int k = 0; k < LANES; k++) mw[k] = 0;
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_finish", finish, 1'b0);
    check("rstmid_par_out", par_out, 32'h0);
    tick();
    #2 reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rstmid_no_finish", finish, 1'b0);
      check("rstmid_idle", busy, 1'b0);
    end

`ifdef LSC_MSB_FIRST_EN
    do_load(32'h000000C0);
    ser_out_ready = 1'b0; mode = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("msb_first_lane0", ser_out[1:0], 2'b11);
    ser_out_ready = 1'b1;
    for (int b = 0; b < BEATS; b++) tick();
    check("msb_finish", finish, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
